// File: rtl/hazard_pkg.sv
// hazard_pkg
// Shared types and constants for the multi-cycle-aware pipeline hazard unit.
//   fwd_sel_e       : ALU operand source select (regfile, W stage, M stage)
//   RESULT_SRC_LOAD : result_src encoding that marks a load in E
//   mc_state_e      : state of the multi-cycle execute latency tracker
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mc_state_e;

endpackage

// File: rtl/mc_latency_tracker.sv
// mc_latency_tracker
// Tracks how long a fixed-latency multi-cycle op (mul/div) has occupied the
// E stage. The op holds E for MC_LAT cycles in total: the IDLE cycle in which
// it is first seen, MC_LAT-2 counted BUSY cycles, and a final BUSY cycle with
// cnt==0 in which it is allowed to advance.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   mc_start_e  : instruction in E is a multi-cycle op
//   mc_stall    : op must keep holding E this cycle
//   mc_busy     : tracker is in BUSY
//   mc_done     : last E-occupancy cycle of the op
module mc_latency_tracker
    import hazard_pkg::*;
#(
    parameter int MC_LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic mc_start_e,
    output logic mc_stall,
    output logic mc_busy,
    output logic mc_done
);

    localparam logic [7:0] CNT_LOAD = 8'(MC_LAT - 2);

    mc_state_e  state_q, state_d;
    logic [7:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // mc_start_e is ignored in BUSY: the op that started the count is still
    // the one sitting in E, so its level must not re-arm the tracker.
    // Outputs are forced low during reset so an aborted op is invisible.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mc_stall = 1'b0;
        mc_busy  = 1'b0;
        mc_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mc_start_e) begin
                    state_d  = BUSY;
                    cnt_d    = CNT_LOAD;
                    mc_stall = !rst;
                end
            end
            BUSY: begin
                mc_busy = !rst;
                if (cnt_q != 8'd0) begin
                    cnt_d    = cnt_q - 8'd1;
                    mc_stall = !rst;
                end else begin
                    state_d = IDLE;
                    mc_done = !rst;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

endmodule

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc
// Pipeline hazard unit for the RV64 five-stage core: M/W operand forwarding,
// load-use stall, branch/jump flush, and holding E for a fixed-latency
// multi-cycle execute op while bubbles drain into M.
// Optional feature macro: HAZARD_PERF_EN enables saturating stall/flush
// performance counters; without it both counter ports are tied to 0.
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   rs1_d, rs2_d               : sources of the instruction in D
//   rs1_e, rs2_e, rd_e         : sources/destination of the instruction in E
//   result_src_e               : result select in E (01 = load)
//   pcsrc_e                    : non-zero = PC redirect resolved in E
//   mc_start_e                 : instruction in E is a multi-cycle op
//   rd_m, reg_write_m          : M-stage destination and write enable
//   rd_w, reg_write_w          : W-stage destination and write enable
//   stall_f/d/e                : hold F, D, E pipeline registers
//   flush_d/e/m                : clear D, E, M pipeline registers
//   forward_ae, forward_be     : ALU operand select (00 RF, 01 W, 10 M)
//   mc_busy, mc_done           : multi-cycle tracker status
//   stall_cnt, flush_cnt       : performance counters
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int RADDR_W = 5,
    parameter int MC_LAT  = 4,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [RADDR_W-1:0] rs1_d,
    input  logic [RADDR_W-1:0] rs2_d,
    input  logic [RADDR_W-1:0] rs1_e,
    input  logic [RADDR_W-1:0] rs2_e,
    input  logic [RADDR_W-1:0] rd_e,
    input  logic [1:0]         result_src_e,
    input  logic [1:0]         pcsrc_e,
    input  logic               mc_start_e,
    input  logic [RADDR_W-1:0] rd_m,
    input  logic               reg_write_m,
    input  logic [RADDR_W-1:0] rd_w,
    input  logic               reg_write_w,
    output logic               stall_f,
    output logic               stall_d,
    output logic               stall_e,
    output logic               flush_d,
    output logic               flush_e,
    output logic               flush_m,
    output logic [1:0]         forward_ae,
    output logic [1:0]         forward_be,
    output logic               mc_busy,
    output logic               mc_done,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    logic mc_stall;
    logic load_use;
    logic redirect;

    mc_latency_tracker #(
        .MC_LAT (MC_LAT)
    ) u_tracker (
        .clk        (clk),
        .rst        (rst),
        .mc_start_e (mc_start_e),
        .mc_stall   (mc_stall),
        .mc_busy    (mc_busy),
        .mc_done    (mc_done)
    );

    // M beats W because it holds the younger write to the same register;
    // x0 is never forwarded since it is hardwired to zero.
    function automatic fwd_sel_e fwd_pick(
        input logic [RADDR_W-1:0] rs,
        input logic [RADDR_W-1:0] dst_m,
        input logic               we_m,
        input logic [RADDR_W-1:0] dst_w,
        input logic               we_w
    );
        if (we_m && (dst_m != '0) && (dst_m == rs))
            return FWD_MEM;
        else if (we_w && (dst_w != '0) && (dst_w == rs))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    always_comb begin
        forward_ae = FWD_RF;
        forward_be = FWD_RF;
        if (!rst) begin
            forward_ae = fwd_pick(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
            forward_be = fwd_pick(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);
        end
    end

    assign load_use = (result_src_e == RESULT_SRC_LOAD) && (rd_e != '0) &&
                      ((rd_e == rs1_d) || (rd_e == rs2_d));
    assign redirect = (pcsrc_e != 2'b00);

    // A held multi-cycle op outranks a redirect: the branch behind it is not
    // really resolved until the op leaves E. A redirect in turn cancels the
    // load-use stall because the dependent instruction in D is discarded.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_m = 1'b0;
        if (rst) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_m = 1'b1;
        end else if (mc_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
        end else if (redirect) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Saturating counters; flush_d/flush_e are forced high in reset, so the
    // reset branch keeps those cycles out of the flush count.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_f && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if ((flush_d || flush_e) && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
